bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter_pkg.sv | 21 ++
 rtl/bram_port_arbiter_if.sv | 37 +++
 rtl/bram_arb_pick.sv | 33 +++
 rtl/bram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the two-port BRAM arbiter: FSM states, port count and port index.
package bram_port_arbiter_pkg;

    localparam int N_PORTS = 2;
    localparam int PORT_W  = 1;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // The picker guarantees one-hot (or zero) input, so bit 1 alone names the port.
    function automatic port_idx_t onehot_to_idx(input logic [N_PORTS-1:0] oh);
        return port_idx_t'(oh[1] & ~oh[0]);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signals of the arbiter; slave = arbiter, master = requesters/BRAM model.
interface bram_port_arbiter_if;
    logic        m0_req,    m1_req;
    logic [3:0]  m0_we,     m1_we;
    logic [31:0] m0_addr,   m1_addr;
    logic [31:0] m0_wdata,  m1_wdata;
    logic        m0_gnt,    m1_gnt;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata,  m1_rdata;
    logic        m0_err,    m1_err;

    logic        bram_clk;
    logic        bram_rst;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_dout;
    logic [31:0] bram_din;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_dout,
        input  bram_din
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  bram_clk, bram_rst, bram_en, bram_we, bram_addr, bram_dout,
        output bram_din
    );
endinterface

// File: rtl/bram_arb_pick.sv
// Winner selection: round-robin on the last-grant pointer, or fixed priority to port 0
// when BRAM_ARB_FIXED_PRIO_EN is defined. Purely combinational.
module bram_arb_pick
    import bram_port_arbiter_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  port_idx_t          last_i,
    output logic [N_PORTS-1:0] gnt_o
);

`ifdef BRAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        gnt_o = '0;
        if (req_i[0]) begin
            gnt_o[0] = 1'b1;
        end else if (req_i[1]) begin
            gnt_o[1] = 1'b1;
        end
    end
`else
    always_comb begin
        gnt_o = req_i;
        // Contention: favour whichever port did not win last time.
        if (req_i == 2'b11) begin
            gnt_o = (last_i == 1'b1) ? 2'b01 : 2'b10;
        end
    end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester BRAM arbiter, one access in flight: write gnt 1 cycle after req, read rvalid 3 cycles after.
// Requests seen outside IDLE wait; BRAM_ARB_FIXED_PRIO_EN swaps round-robin for port-0 priority.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0002_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_port_arbiter_if.slave    arb_if
);

    state_e      state_q, state_d;
    port_idx_t   sel_q, win_idx, last_ptr;
    logic [1:0]  req_vec, pick_gnt;
    logic [3:0]  we_q, win_we;
    logic [31:0] off_q, wdata_q, win_off, win_wdata;
    logic        err_q;
    logic [31:0] rdata0_q, rdata1_q;

    assign req_vec   = {arb_if.m1_req, arb_if.m0_req};
    assign win_idx   = onehot_to_idx(pick_gnt);
    assign win_we    = win_idx ? arb_if.m1_we    : arb_if.m0_we;
    assign win_wdata = win_idx ? arb_if.m1_wdata : arb_if.m0_wdata;
    assign win_off   = (win_idx ? arb_if.m1_addr : arb_if.m0_addr) - BASE_ADDR;

    bram_arb_pick u_pick (
        .req_i  (req_vec),
        .last_i (last_ptr),
        .gnt_o  (pick_gnt)
    );

`ifdef BRAM_ARB_FIXED_PRIO_EN
    assign last_ptr = 1'b0;
`else
    port_idx_t last_q;
    assign last_ptr = last_q;

    // Reset to port 1 so port 0 takes the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == ST_IDLE && |req_vec) begin
            last_q <= win_idx;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_vec) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (we_q != 4'h0) ? ST_IDLE : ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            we_q     <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == ST_IDLE && |req_vec) begin
                sel_q   <= win_idx;
                we_q    <= win_we;
                off_q   <= win_off;
                wdata_q <= win_wdata;
                err_q   <= (win_off >= MEM_SIZE);
            end
            // Out-of-range reads never touched the BRAM, so return zero instead of bram_din.
            if (state_q == ST_WAIT) begin
                if (sel_q == 1'b0) begin
                    rdata0_q <= err_q ? 32'h0 : arb_if.bram_din;
                end else begin
                    rdata1_q <= err_q ? 32'h0 : arb_if.bram_din;
                end
            end
        end
    end

    assign arb_if.bram_clk = clk;
    assign arb_if.bram_rst = ~rst_n;
    assign arb_if.m0_rdata = rdata0_q;
    assign arb_if.m1_rdata = rdata1_q;

    always_comb begin
        arb_if.m0_gnt    = 1'b0;
        arb_if.m1_gnt    = 1'b0;
        arb_if.m0_err    = 1'b0;
        arb_if.m1_err    = 1'b0;
        arb_if.m0_rvalid = 1'b0;
        arb_if.m1_rvalid = 1'b0;
        arb_if.bram_en   = 1'b0;
        arb_if.bram_we   = 4'h0;
        arb_if.bram_addr = 32'h0;
        arb_if.bram_dout = 32'h0;
        if (state_q == ST_ISSUE) begin
            arb_if.m0_gnt    = (sel_q == 1'b0);
            arb_if.m1_gnt    = (sel_q == 1'b1);
            arb_if.m0_err    = (sel_q == 1'b0) && err_q;
            arb_if.m1_err    = (sel_q == 1'b1) && err_q;
            arb_if.bram_en   = ~err_q;
            arb_if.bram_we   = err_q ? 4'h0 : we_q;
            arb_if.bram_addr = off_q;
            arb_if.bram_dout = wdata_q;
        end
        if (state_q == ST_RESP) begin
            arb_if.m0_rvalid = (sel_q == 1'b0);
            arb_if.m1_rvalid = (sel_q == 1'b1);
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Cycle-by-cycle vector bench for bram_port_arbiter plus a mid-access reset sequence.
module tb_bram_port_arbiter;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MEMS = 32'h0002_0000;

    typedef struct packed {
        logic        req0, req1;
        logic [3:0]  we0, we1;
        logic [31:0] a0, a1, d0, d1, din;
    } in_t;

    typedef struct packed {
        logic        gnt0, gnt1, err0, err1, rv0, rv1, en;
        logic [3:0]  we;
        logic [31:0] addr, dout, rd0, rd1;
    } out_t;

    typedef struct packed {
        in_t         i;
        out_t        o;
        logic [47:0] tag;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    bram_port_arbiter_if bus ();

    bram_port_arbiter #(
        .BASE_ADDR (BASE),
        .MEM_SIZE  (MEMS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t i_none(input logic [31:0] din);
        in_t v = '0;
        v.din = din;
        return v;
    endfunction

    function automatic in_t i_one(input bit p, input logic [3:0] we,
                                  input logic [31:0] a, input logic [31:0] d);
        in_t v = '0;
        if (p) begin v.req1 = 1'b1; v.we1 = we; v.a1 = a; v.d1 = d; end
        else   begin v.req0 = 1'b1; v.we0 = we; v.a0 = a; v.d0 = d; end
        return v;
    endfunction

    function automatic in_t i_both(input logic [31:0] a0, input logic [31:0] a1,
                                   input logic [31:0] din);
        in_t v = '0;
        v.req0 = 1'b1; v.a0 = a0;
        v.req1 = 1'b1; v.a1 = a1;
        v.din  = din;
        return v;
    endfunction

    function automatic out_t o_none(input logic [31:0] r0, input logic [31:0] r1);
        out_t o = '0;
        o.rd0 = r0;
        o.rd1 = r1;
        return o;
    endfunction

    function automatic out_t o_acc(input bit p, input bit err, input logic [3:0] we,
                                   input logic [31:0] off, input logic [31:0] dout,
                                   input logic [31:0] r0, input logic [31:0] r1);
        out_t o = o_none(r0, r1);
        if (p) begin o.gnt1 = 1'b1; o.err1 = err; end
        else   begin o.gnt0 = 1'b1; o.err0 = err; end
        o.en   = ~err;
        o.we   = err ? 4'h0 : we;
        o.addr = off;
        o.dout = dout;
        return o;
    endfunction

    function automatic out_t o_resp(input bit p, input logic [31:0] r0, input logic [31:0] r1);
        out_t o = o_none(r0, r1);
        if (p) o.rv1 = 1'b1;
        else   o.rv0 = 1'b1;
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o, input logic [47:0] tag);
        vec_t v;
        v.i = i; v.o = o; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        bus.m0_req = v.req0; bus.m0_we = v.we0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
        bus.m1_req = v.req1; bus.m1_we = v.we1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
        bus.bram_din = v.din;
    endtask

    function automatic out_t sample();
        out_t o;
        o.gnt0 = bus.m0_gnt;    o.gnt1 = bus.m1_gnt;
        o.err0 = bus.m0_err;    o.err1 = bus.m1_err;
        o.rv0  = bus.m0_rvalid; o.rv1  = bus.m1_rvalid;
        o.en   = bus.bram_en;   o.we   = bus.bram_we;
        o.addr = bus.bram_addr; o.dout = bus.bram_dout;
        o.rd0  = bus.m0_rdata;  o.rd1  = bus.m1_rdata;
        return o;
    endfunction

    task automatic check(input out_t exp, input logic [47:0] tag);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", tag, n_vec, act, exp);
        end
    endtask

    task automatic step_check(input in_t i, input out_t o, input logic [47:0] tag);
        drive(i);
        @(posedge clk);
        #1;
        check(o, tag);
    endtask

    initial begin
        logic [31:0] r0, r1, val;
        bit          p;

        n_vec = 0;
        n_err = 0;
        r0 = '0;
        r1 = '0;

        // Single m0 write, then single m1 read returning 0xDEADBEEF.
        add(i_one(0, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF), o_acc(0, 0, 4'hF, 32'h10, 32'hDEAD_BEEF, r0, r1), "wr_m0 ");
        add(i_none(0), o_none(r0, r1), "wr_end");
        add(i_one(1, 4'h0, BASE + 32'h10, 32'h0), o_acc(1, 0, 4'h0, 32'h10, 32'h0, r0, r1), "rd_m1 ");
        add(i_none(0), o_none(r0, r1), "rd_wt ");
        r1 = 32'hDEAD_BEEF;
        add(i_none(32'hDEAD_BEEF), o_resp(1, r0, r1), "rd_rv ");
        add(i_none(0), o_none(r0, r1), "rd_end");

        // Both ports hold read requests for four back-to-back accesses.
        for (int j = 0; j < 4; j++) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            p = 1'b0;
`else
            p = (j % 2) == 1;
`endif
            val = 32'hA000_0000 | j;
            add(i_both(BASE + 32'h20, BASE + 32'h24, 0),
                o_acc(p, 0, 4'h0, p ? 32'h24 : 32'h20, 32'h0, r0, r1), "rr_gnt");
            add((j < 3) ? i_both(BASE + 32'h20, BASE + 32'h24, 0) : i_none(0), o_none(r0, r1), "rr_wt ");
            if (p) r1 = val;
            else   r0 = val;
            add((j < 3) ? i_both(BASE + 32'h20, BASE + 32'h24, val) : i_none(val), o_resp(p, r0, r1), "rr_rv ");
            add((j < 3) ? i_both(BASE + 32'h20, BASE + 32'h24, 0) : i_none(0), o_none(r0, r1), "rr_end");
        end

        // m1 partial write: no WAIT/RESP afterwards.
        add(i_one(1, 4'b0011, BASE + 32'h40, 32'hCAFE_F00D), o_acc(1, 0, 4'b0011, 32'h40, 32'hCAFE_F00D, r0, r1), "pw_m1 ");
        add(i_none(0), o_none(r0, r1), "pw_idl");
        add(i_none(0), o_none(r0, r1), "pw_nrv");

        // Write exactly one past the end: granted with err, BRAM untouched.
        add(i_one(0, 4'hF, BASE + MEMS, 32'h1234_5678), o_acc(0, 1, 4'hF, MEMS, 32'h1234_5678, r0, r1), "oor_wr");
        add(i_none(0), o_none(r0, r1), "oor_id");

        // Read below BASE wraps to a huge offset: err, and rdata forced to 0.
        add(i_one(1, 4'h0, BASE - 32'h4, 32'h0), o_acc(1, 1, 4'h0, 32'hFFFF_FFFC, 32'h0, r0, r1), "oor_rd");
        add(i_none(0), o_none(r0, r1), "oor_wt");
        r1 = 32'h0;
        add(i_none(32'hAAAA_5555), o_resp(1, r0, r1), "oor_rv");
        add(i_none(0), o_none(r0, r1), "oor_en");

        // Last valid word is served normally.
        add(i_one(0, 4'h0, BASE + MEMS - 32'h4, 32'h0), o_acc(0, 0, 4'h0, MEMS - 32'h4, 32'h0, r0, r1), "top_rd");
        add(i_none(0), o_none(r0, r1), "top_wt");
        r0 = 32'h5A5A_5A5A;
        add(i_none(32'h5A5A_5A5A), o_resp(0, r0, r1), "top_rv");
        add(i_none(0), o_none(r0, r1), "top_en");

        // Reset state.
        rst_n = 1'b0;
        drive(i_none(0));
        repeat (2) @(posedge clk);
        #1;
        check(o_none(0, 0), "rst_st");
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            step_check(vecs[k].i, vecs[k].o, vecs[k].tag);
        end

        // Reset pulse while an m1 read sits in WAIT.
        step_check(i_one(1, 4'h0, BASE + 32'h50, 32'h0), o_acc(1, 0, 4'h0, 32'h50, 32'h0, r0, r1), "ab_gnt");
        step_check(i_none(0), o_none(r0, r1), "ab_wt ");
        drive(i_none(32'h7777_7777));
        rst_n = 1'b0;
        #2;
        check(o_none(0, 0), "ab_rst");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step_check(i_none(32'h7777_7777), o_none(0, 0), "ab_quiet");
        end
        step_check(i_one(0, 4'hF, BASE + 32'h60, 32'hBEEF_0001), o_acc(0, 0, 4'hF, 32'h60, 32'hBEEF_0001, 0, 0), "ab_m0 ");
        step_check(i_none(0), o_none(0, 0), "ab_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
